row_cache_scheduler: RTL and testbench

Sequences feature_row_Cache for one feature map at a time.
- Latches the frame geometry and pulses rebuild_structure to the cache.
- Gates incoming feature beats into the cache and tracks column and row position.
- Withholds window-valid until KERNEL-1 full rows are buffered, applies downstream backpressure, and signals end of frame.
- Sits between the conv-layer control FSM and feature_row_Cache.

---
 rtl/row_cache_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_row_cache_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/row_cache_scheduler.sv
// Frame sequencer for feature_row_Cache: latches geometry, gates beats, and tracks window readiness and end of frame.
// Optional ROW_CACHE_STALL_CNT_EN adds a saturating stall_cycles counter of upstream beats stalled in FILL/RUN.
module row_cache_scheduler #(
    parameter int KERNEL = 3,
    parameter int COL_W  = 10,
    parameter int ROW_W  = 10
) (
    input  logic             system_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [COL_W-1:0] cfg_col_size,
    input  logic [ROW_W-1:0] cfg_row_size,
    input  logic             feature_in_valid,
    output logic             feature_in_ready,
    input  logic             win_ready,
    output logic             rebuild_structure,
    output logic [COL_W-1:0] col_size,
    output logic             cache_write_en,
    output logic [COL_W-1:0] col_cnt,
    output logic [ROW_W-1:0] row_cnt,
    output logic             window_valid,
    output logic             frame_done,
    output logic             cfg_error,
    output logic             busy
`ifdef ROW_CACHE_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_CONFIG, S_FILL, S_RUN, S_DONE} state_t;

    localparam logic [COL_W-1:0] K_COL    = COL_W'(KERNEL);
    localparam logic [ROW_W-1:0] K_ROW    = ROW_W'(KERNEL);
    localparam logic [ROW_W-1:0] K_ROW_M2 = ROW_W'((KERNEL > 1) ? KERNEL - 2 : 0);
    localparam logic [COL_W:0]   K_COL_X  = (COL_W+1)'(KERNEL);

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_size_q, col_size_d;
    logic [ROW_W-1:0]   row_size_q, row_size_d;
    logic [COL_W-1:0]   col_pos_q, col_pos_d;
    logic [ROW_W-1:0]   row_pos_q, row_pos_d;
    logic               wen_q, wen_d;
    logic [COL_W-1:0]   col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;
    logic               win_q, win_d;
    logic               cfg_err_q, cfg_err_d;
    logic               ready_c;
    logic               accept_c;
    logic               last_col_c;
    logic               last_row_c;
    logic               win_col_c;

    always_comb begin
        state_d    = state_q;
        col_size_d = col_size_q;
        row_size_d = row_size_q;
        col_pos_d  = col_pos_q;
        row_pos_d  = row_pos_q;
        col_cnt_d  = col_cnt_q;
        row_cnt_d  = row_cnt_q;
        wen_d      = 1'b0;
        win_d      = 1'b0;
        cfg_err_d  = 1'b0;
        ready_c    = 1'b0;

        case (state_q)
            S_FILL:  ready_c = 1'b1;
            S_RUN:   ready_c = win_ready;
            default: ready_c = 1'b0;
        endcase
        accept_c   = feature_in_valid && ready_c;
        last_col_c = (col_pos_q == col_size_q - COL_W'(1));
        last_row_c = (row_pos_q == row_size_q - ROW_W'(1));
        // A window needs KERNEL columns to the left of and including this beat.
        win_col_c  = ({1'b0, col_pos_q} + (COL_W+1)'(1)) >= K_COL_X;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((cfg_col_size < K_COL) || (cfg_row_size < K_ROW)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        col_size_d = cfg_col_size;
                        row_size_d = cfg_row_size;
                        state_d    = S_CONFIG;
                    end
                end
            end
            S_CONFIG: begin
                col_pos_d = '0;
                row_pos_d = '0;
                col_cnt_d = '0;
                row_cnt_d = '0;
                state_d   = (KERNEL > 1) ? S_FILL : S_RUN;
            end
            S_FILL, S_RUN: begin
                if (accept_c) begin
                    wen_d     = 1'b1;
                    col_cnt_d = col_pos_q;
                    row_cnt_d = row_pos_q;
                    win_d     = (state_q == S_RUN) && win_col_c;
                    if (last_col_c) begin
                        col_pos_d = '0;
                        row_pos_d = row_pos_q + ROW_W'(1);
                        if (state_q == S_FILL && row_pos_q == K_ROW_M2) begin
                            state_d = S_RUN;
                        end
                        if (state_q == S_RUN && last_row_c) begin
                            state_d   = S_DONE;
                            row_pos_d = '0;
                        end
                    end else begin
                        col_pos_d = col_pos_q + COL_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            col_size_q <= '0;
            row_size_q <= '0;
            col_pos_q  <= '0;
            row_pos_q  <= '0;
            wen_q      <= 1'b0;
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
            win_q      <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_size_q <= col_size_d;
            row_size_q <= row_size_d;
            col_pos_q  <= col_pos_d;
            row_pos_q  <= row_pos_d;
            wen_q      <= wen_d;
            col_cnt_q  <= col_cnt_d;
            row_cnt_q  <= row_cnt_d;
            win_q      <= win_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

`ifdef ROW_CACHE_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_CONFIG) begin
            stall_d = '0;
        end else if ((state_q == S_FILL || state_q == S_RUN) && feature_in_valid && !ready_c
                     && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign feature_in_ready  = ready_c;
    assign rebuild_structure = (state_q == S_CONFIG);
    assign col_size          = col_size_q;
    assign cache_write_en    = wen_q;
    assign col_cnt           = col_cnt_q;
    assign row_cnt           = row_cnt_q;
    assign window_valid      = win_q;
    assign frame_done        = (state_q == S_DONE);
    assign cfg_error         = cfg_err_q;
    assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_row_cache_scheduler.sv
// Directed plus randomized frames for row_cache_scheduler (KERNEL=3 and KERNEL=1 instances) against a beat-index model.
// Latency: checks sample registered outputs one cycle after the accepted beat.
// Backpressure: win_ready driven always-high, toggling, random and fully stalled.
module tb_row_cache_scheduler;
    localparam int K     = 3;
    localparam int COL_W = 10;
    localparam int ROW_W = 10;

    logic             system_clk = 1'b0;
    logic             rst_n;
    logic             start, start_1;
    logic [COL_W-1:0] cfg_col_size;
    logic [ROW_W-1:0] cfg_row_size;
    logic             feature_in_valid, win_ready;

    logic             ready3, rebuild3, wen3, win3, done3, cerr3, busy3;
    logic [COL_W-1:0] col_size3, col_cnt3;
    logic [ROW_W-1:0] row_cnt3;
    logic             ready1, rebuild1, wen1, win1, done1, cerr1, busy1;
    logic [COL_W-1:0] col_size1, col_cnt1;
    logic [ROW_W-1:0] row_cnt1;
    logic [36:0]      outs3;
`ifdef ROW_CACHE_STALL_CNT_EN
    logic [31:0]      stall3, stall1;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: n-th accepted beat of a frame sits at (n % cols, n / cols).
    int  m_cs, m_rs;
    int  acc_n, beat_n, win_n, reb_n, cerr_n, done_n, stall_exp;
    bit  done_seen;

    row_cache_scheduler #(.KERNEL(K), .COL_W(COL_W), .ROW_W(ROW_W)) dut3 (
        .system_clk(system_clk), .rst_n(rst_n), .start(start),
        .cfg_col_size(cfg_col_size), .cfg_row_size(cfg_row_size),
        .feature_in_valid(feature_in_valid), .feature_in_ready(ready3),
        .win_ready(win_ready), .rebuild_structure(rebuild3), .col_size(col_size3),
        .cache_write_en(wen3), .col_cnt(col_cnt3), .row_cnt(row_cnt3),
        .window_valid(win3), .frame_done(done3), .cfg_error(cerr3), .busy(busy3)
`ifdef ROW_CACHE_STALL_CNT_EN
        , .stall_cycles(stall3)
`endif
    );

    row_cache_scheduler #(.KERNEL(1), .COL_W(COL_W), .ROW_W(ROW_W)) dut1 (
        .system_clk(system_clk), .rst_n(rst_n), .start(start_1),
        .cfg_col_size(cfg_col_size), .cfg_row_size(cfg_row_size),
        .feature_in_valid(feature_in_valid), .feature_in_ready(ready1),
        .win_ready(win_ready), .rebuild_structure(rebuild1), .col_size(col_size1),
        .cache_write_en(wen1), .col_cnt(col_cnt1), .row_cnt(row_cnt1),
        .window_valid(win1), .frame_done(done1), .cfg_error(cerr1), .busy(busy1)
`ifdef ROW_CACHE_STALL_CNT_EN
        , .stall_cycles(stall1)
`endif
    );

    assign outs3 = {ready3, rebuild3, col_size3, wen3, col_cnt3, row_cnt3, win3, done3, cerr3, busy3};

    always #5 system_clk = ~system_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge system_clk) begin
        if (rst_n) begin
            if (rebuild3) reb_n++;
            if (cerr3) cerr_n++;
            if (feature_in_valid && !win_ready && busy3 && acc_n >= (K-1)*m_cs && acc_n < m_cs*m_rs)
                stall_exp++;
            if (feature_in_valid && ready3) acc_n++;
            if (wen3) begin
                check("beat_col", int'(col_cnt3), beat_n % m_cs);
                check("beat_row", int'(row_cnt3), beat_n / m_cs);
                check("beat_window", win3,
                      ((beat_n / m_cs) >= K-1 && (beat_n % m_cs) >= K-1) ? 1'b1 : 1'b0);
                beat_n++;
            end
            if (win3) win_n++;
            if (done3) begin
                done_n++;
                done_seen = 1'b1;
                check("done_after_last_beat", beat_n, m_cs*m_rs);
            end
        end
    end

    task automatic clear_stats(input int cs, input int rs);
        m_cs = cs; m_rs = rs;
        acc_n = 0; beat_n = 0; win_n = 0; reb_n = 0; cerr_n = 0; done_n = 0; stall_exp = 0;
        done_seen = 1'b0;
    endtask

    // mode 0: always ready; 1: win_ready toggles from row 2; 2: random; 3: downstream stalled for 60 cycles
    task automatic run_frame(input int cs, input int rs, input int mode, input int restart_at, input int abort_at);
        bit restarted = 1'b0;
        bit aborted = 1'b0;
        clear_stats(cs, rs);
        @(posedge system_clk); #1;
        cfg_col_size = COL_W'(cs); cfg_row_size = ROW_W'(rs);
        start = 1'b1; feature_in_valid = 1'b0; win_ready = 1'b0;
        @(posedge system_clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (done_seen) break;
            if (abort_at >= 0 && acc_n >= abort_at) begin aborted = 1'b1; break; end
            if (mode == 3 && cyc == 60) check("fill_beats_before_stall", acc_n, (K-1)*cs);
            case (mode)
                1: begin feature_in_valid = 1'b1; win_ready = (acc_n < 2*cs) ? 1'b1 : cyc[0]; end
                2: begin feature_in_valid = ($urandom_range(0, 3) != 0); win_ready = $urandom_range(0, 1) != 0; end
                3: begin feature_in_valid = 1'b1; win_ready = (cyc >= 60); end
                default: begin feature_in_valid = 1'b1; win_ready = 1'b1; end
            endcase
            start = 1'b0;
            if (restart_at >= 0 && !restarted && acc_n >= restart_at) begin
                start = 1'b1; cfg_col_size = COL_W'(4); cfg_row_size = ROW_W'(4); restarted = 1'b1;
            end
            @(posedge system_clk); #1;
        end
        start = 1'b0;
        if (aborted) begin
            #2 rst_n = 1'b0;
            #1 check("async_reset_outputs", outs3, 37'd0);
            @(posedge system_clk); #1;
            rst_n = 1'b1; feature_in_valid = 1'b0; win_ready = 1'b0;
        end else begin
            check("frame_done_seen", done_seen, 1'b1);
            check("busy_after_done", busy3, 1'b0);
            check("rebuild_pulses", reb_n, 1);
            check("accepts", acc_n, cs*rs);
            check("windows", win_n, (rs-K+1)*(cs-K+1));
            check("frame_done_pulses", done_n, 1);
            check("col_size_latched", int'(col_size3), cs);
`ifdef ROW_CACHE_STALL_CNT_EN
            check("stall_cycles", int'(stall3), stall_exp);
`endif
            feature_in_valid = 1'b0; win_ready = 1'b0;
        end
    endtask

    initial begin
        bit ready_seen;
        int n1, w1;
        rst_n = 1'b0; start = 1'b0; start_1 = 1'b0;
        cfg_col_size = '0; cfg_row_size = '0; feature_in_valid = 1'b0; win_ready = 1'b0;
        clear_stats(1, 1);
        #22;
        check("reset_outputs", outs3, 37'd0);
        @(posedge system_clk); #1 rst_n = 1'b1;

        run_frame(18, 5, 0, -1, -1);
        run_frame(18, 5, 1, -1, -1);

        // illegal geometry: too few columns for the kernel
        clear_stats(2, 5);
        cfg_col_size = COL_W'(2); cfg_row_size = ROW_W'(5); start = 1'b1;
        feature_in_valid = 1'b1;
        @(posedge system_clk); #1 start = 1'b0;
        ready_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (ready3 || busy3) ready_seen = 1'b1;
            @(posedge system_clk); #1;
        end
        feature_in_valid = 1'b0;
        check("cfg_error_pulses", cerr_n, 1);
        check("illegal_no_rebuild", reb_n, 0);
        check("illegal_idle_quiet", ready_seen, 1'b0);

        run_frame(18, 5, 0, 50, -1);
        run_frame(18, 5, 3, -1, 40);
        run_frame(10, 3, 0, -1, -1);
        for (int f = 0; f < 3; f++) run_frame($urandom_range(3, 12), $urandom_range(3, 6), 2, -1, -1);

        // KERNEL=1: no fill phase, every beat carries a window
        cfg_col_size = COL_W'(4); cfg_row_size = ROW_W'(2);
        start_1 = 1'b1; feature_in_valid = 1'b1; win_ready = 1'b1;
        @(posedge system_clk); #1 start_1 = 1'b0;
        n1 = 0; w1 = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge system_clk); #1;
            if (wen1) begin
                check("k1_col", int'(col_cnt1), n1 % 4);
                check("k1_row", int'(row_cnt1), n1 / 4);
                n1++;
            end
            if (win1) w1++;
            if (done1) break;
        end
        check("k1_frame_done", done1, 1'b1);
        check("k1_beats", n1, 8);
        check("k1_windows", w1, 8);
        @(posedge system_clk); #1;
        check("k1_busy_after_done", busy1, 1'b0);
        feature_in_valid = 1'b0; win_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
